// File: rtl/marks_receiver_if.sv
// Handshake bundle between the teacher-side writer, the principal override
// strobe and the student-side reader of assembled mark records.
interface marks_receiver_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       ovr_valid;
    logic [7:0] ovr_lab;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_math;
    logic [7:0] out_physics;
    logic [7:0] out_lab;
    logic [9:0] out_total;
    logic       out_pass;
    logic       out_err;
    logic [7:0] rec_count;

    // valid/ready: a transfer happens at a rising edge where both are high;
    // valid may not depend on ready, and the sender holds its payload until taken.
    modport master (
        output in_valid, in_data, ovr_valid, ovr_lab, out_ready,
        input  in_ready, out_valid, out_math, out_physics, out_lab,
               out_total, out_pass, out_err, rec_count
    );

    modport slave (
        input  in_valid, in_data, ovr_valid, ovr_lab, out_ready,
        output in_ready, out_valid, out_math, out_physics, out_lab,
               out_total, out_pass, out_err, rec_count
    );
endinterface

// File: rtl/marks_receiver.sv
// Collects math, physics and lab marks byte by byte, presents them as one
// record with total/pass/error flags, and lets the principal override the lab mark.
module marks_receiver #(
    parameter logic [7:0] PASS_MARK = 8'd40,
    parameter logic [7:0] MAX_MARK  = 8'd100
) (
    input  logic             clk,
    input  logic             rst_n,
    marks_receiver_if.slave  bus,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_MATH = 2'd0,
        S_PHYS = 2'd1,
        S_LAB  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       accept;
    logic       deliver;
    logic [7:0] math_q, phys_q, lab_q;
    logic [7:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_MATH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        deliver = 1'b0;
        case (state_q)
            S_MATH: if (bus.in_valid) begin
                accept  = 1'b1;
                state_d = S_PHYS;
            end
            S_PHYS: if (bus.in_valid) begin
                accept  = 1'b1;
                state_d = S_LAB;
            end
            S_LAB: if (bus.in_valid) begin
                accept  = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: if (bus.out_ready) begin
                deliver = 1'b1;
                state_d = S_MATH;
            end
            default: state_d = S_MATH;
        endcase
    end

    // An override is honoured only alongside the lab byte or while the record
    // is stalled; one arriving with the handshake would alter a delivered record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            math_q  <= 8'd0;
            phys_q  <= 8'd0;
            lab_q   <= 8'd0;
            count_q <= 8'd0;
        end else begin
            if (accept) begin
                case (state_q)
                    S_MATH:  math_q <= bus.in_data;
                    S_PHYS:  phys_q <= bus.in_data;
                    S_LAB:   lab_q  <= bus.ovr_valid ? bus.ovr_lab : bus.in_data;
                    default: ;
                endcase
            end
            if (state_q == S_OUT && !bus.out_ready && bus.ovr_valid) begin
                lab_q <= bus.ovr_lab;
            end
            if (deliver) begin
                count_q <= count_q + 8'd1;
            end
        end
    end

    assign bus.in_ready    = (state_q != S_OUT);
    assign bus.out_valid   = (state_q == S_OUT);
    assign bus.out_math    = math_q;
    assign bus.out_physics = phys_q;
    assign bus.out_lab     = lab_q;
    assign bus.out_total   = {2'b00, math_q} + {2'b00, phys_q} + {2'b00, lab_q};
    assign bus.out_pass    = (math_q >= PASS_MARK) && (phys_q >= PASS_MARK) && (lab_q >= PASS_MARK);
    assign bus.out_err     = (math_q > MAX_MARK) || (phys_q > MAX_MARK) || (lab_q > MAX_MARK);
    assign bus.rec_count   = count_q;
    assign dbg_state       = state_q;

endmodule
